alu_decode_exec: RTL and testbench

ALU_DECODE_EXEC -- requirements
Module: alu_decode_exec

---
 rtl/alu_decode_exec.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_decode_exec.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_exec.sv
// RV32/64-style ALU with ALUOp/funct decode, single-cycle integer ops and
// iterative shift-add multiply / restoring divide behind a valid/ready handshake.
module alu_decode_exec #(
    parameter int XLEN    = 32,
    parameter bit MDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDIV = 7'b0000001;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_t;

    function automatic op_t base_op(input logic [2:0] f3);
        op_t op;
        unique case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    state_t            state, state_nxt;
    op_t               dec_op, md_op;
    logic              accept, is_mul, is_div, last;
    logic              a_neg, b_neg, q_neg, r_neg, div_zero;
    logic [XLEN-1:0]   a_mag, b_mag, md_b;
    logic [XLEN-1:0]   alu_res, mul_res, div_res;
    logic [SHW-1:0]    shamt;
    logic [CW-1:0]     cnt;
    logic [2*XLEN:0]   prod, prod_nxt;
    logic [XLEN:0]     mul_add;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   rem, quo, rem_nxt, quo_nxt, div_sub;
    logic [XLEN:0]     div_shift;
    logic              div_ge;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec_op = OP_ILL;
        unique case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                if (funct7 == F7_BASE) begin
                    dec_op = base_op(funct3);
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      dec_op = OP_SUB;
                    else if (funct3 == 3'b101) dec_op = OP_SRA;
                end else if (MDIV_EN && funct7 == F7_MDIV) begin
                    unique case (funct3)
                        3'b000:  dec_op = OP_MUL;
                        3'b001:  dec_op = OP_MULH;
                        3'b010:  dec_op = OP_MULHSU;
                        3'b011:  dec_op = OP_MULHU;
                        3'b100:  dec_op = OP_DIV;
                        3'b101:  dec_op = OP_DIVU;
                        3'b110:  dec_op = OP_REM;
                        default: dec_op = OP_REMU;
                    endcase
                end
            end
            default: begin
                // Immediate forms: funct7 only matters for the shifts.
                if (funct3 == 3'b001) begin
                    if (funct7 == F7_BASE) dec_op = OP_SLL;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_BASE)     dec_op = OP_SRL;
                    else if (funct7 == F7_ALT) dec_op = OP_SRA;
                end else begin
                    dec_op = base_op(funct3);
                end
            end
        endcase
    end

    assign is_mul = dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign is_div = dec_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign a_neg  = (dec_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && op_a[XLEN-1];
    assign b_neg  = (dec_op inside {OP_MULH, OP_DIV, OP_REM}) && op_b[XLEN-1];
    assign a_mag  = a_neg ? -op_a : op_a;
    assign b_mag  = b_neg ? -op_b : op_b;
    assign shamt  = op_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        unique case (dec_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
    end

    // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
    always_comb begin
        mul_add  = prod[2*XLEN:XLEN] + (prod[0] ? {1'b0, md_b} : {(XLEN+1){1'b0}});
        prod_nxt = {1'b0, mul_add, prod[XLEN-1:1]};
        prod_fix = q_neg ? -prod_nxt[2*XLEN-1:0] : prod_nxt[2*XLEN-1:0];
        mul_res  = (md_op == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    // Restoring step; a zero divisor naturally yields an all-ones quotient and rem = dividend.
    always_comb begin
        div_shift = {rem, quo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, md_b};
        div_sub   = div_shift[XLEN-1:0] - md_b;
        rem_nxt   = div_ge ? div_sub : div_shift[XLEN-1:0];
        quo_nxt   = {quo[XLEN-2:0], div_ge};
        div_res   = '0;
        if (md_op inside {OP_DIV, OP_DIVU}) begin
            if (div_zero)   div_res = '1;
            else if (q_neg) div_res = -quo_nxt;
            else            div_res = quo_nxt;
        end else begin
            div_res = r_neg ? -rem_nxt : rem_nxt;
        end
    end

    assign last = (cnt == CW'(XLEN - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                accept    = in_valid && out_ready;
                if (out_ready && !in_valid) state_nxt = S_IDLE;
            end
            S_MUL, S_DIV: begin
                if (last) state_nxt = S_DONE;
            end
        endcase
        if (accept) state_nxt = is_mul ? S_MUL : (is_div ? S_DIV : S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: datapath registers are reset too, so an operation aborted by reset leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_op    <= OP_ADD;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            md_b     <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
        end else if (accept) begin
            md_op    <= dec_op;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            div_zero <= (op_b == '0);
            md_b     <= b_mag;
            prod     <= {{(XLEN+1){1'b0}}, a_mag};
            rem      <= '0;
            quo      <= a_mag;
            cnt      <= '0;
        end else if (state == S_MUL) begin
            prod <= prod_nxt;
            cnt  <= cnt + 1'b1;
        end else if (state == S_DIV) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers only change on a new single-cycle accept or on the last iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
        end else if (accept && !is_mul && !is_div) begin
            result  <= alu_res;
            zero    <= (alu_res == '0);
            illegal <= (dec_op == OP_ILL);
        end else if (state == S_MUL && last) begin
            result  <= mul_res;
            zero    <= (mul_res == '0);
            illegal <= 1'b0;
        end else if (state == S_DIV && last) begin
            result  <= div_res;
            zero    <= (div_res == '0);
            illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_decode_exec.sv
// Scoreboard bench for alu_decode_exec: directed requests push expectations,
// an independent monitor checks each presented result, its latency and its stability.
module tb_alu_decode_exec;

    localparam int XLEN = 32;
    localparam int L1   = 1;
    localparam int LM   = XLEN + 1;
    localparam logic [6:0] F7B = 7'b0000000;
    localparam logic [6:0] F7A = 7'b0100000;
    localparam logic [6:0] F7M = 7'b0000001;
    localparam logic [1:0] R   = 2'b10;
    localparam logic [1:0] I   = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      ALUOp = '0;
    logic [6:0]      funct7 = '0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    alu_decode_exec #(.XLEN(XLEN), .MDIV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string           name;
        logic [XLEN-1:0] res;
        logic            ill;
        int              acc;
        int              lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_acc = 0;
    int   first_acc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        n_checks++;
        n_errors++;
        $display("FAIL %s", msg);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input string name, input logic [1:0] aop, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp_res, input logic exp_ill, input int lat);
        exp_t e;
        bit   took = 1'b0;
        ALUOp = aop; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !took; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.name = name; e.res = exp_res; e.ill = exp_ill; e.acc = cyc; e.lat = lat;
                last_acc = cyc;
                sb.push_back(e);
                took = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!took) fail_now($sformatf("%s accept_timeout: request not taken in 100 cycles", name));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (sb.size() != 0) fail_now($sformatf("drain_timeout: %0d results outstanding", sb.size()));
        @(posedge clk); #1;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    initial begin : monitor
        exp_t e;
        bit   seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        check($sformatf("%s latency", e.name), 64'(cyc - e.acc), 64'(e.lat));
                        seen = 1'b1;
                    end
                    check($sformatf("%s result", e.name), 64'(result), 64'(e.res));
                    check($sformatf("%s zero", e.name), {63'd0, zero}, {63'd0, e.res == '0});
                    check($sformatf("%s illegal", e.name), {63'd0, illegal}, {63'd0, e.ill});
                    if (!out_ready) begin
                        check($sformatf("%s stall in_ready", e.name), {63'd0, in_ready}, 64'd0);
                    end else begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        #1 rst_n = 1'b0;
        #1;
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset zero", {63'd0, zero}, 64'd1);
        check("reset illegal", {63'd0, illegal}, 64'd0);
        check("reset in_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        issue("r_sub", R, F7A, 3'b000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, L1);
        issue("r_mulh", R, F7M, 3'b001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 1'b0, LM);
        issue("div_ovf", R, F7M, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, LM);
        issue("divu_by0", R, F7M, 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, LM);
        issue("remu_by0", R, F7M, 3'b111, 32'd9, 32'd0, 32'd9, 1'b0, LM);

        issue("aluop_add", 2'b00, F7A, 3'b101, 32'd3, 32'd4, 32'd7, 1'b0, L1);
        issue("aluop_sub", 2'b01, F7M, 3'b111, 32'd3, 32'd3, 32'd0, 1'b0, L1);
        issue("r_sll", R, F7B, 3'b001, 32'd1, 32'h24, 32'h10, 1'b0, L1);
        issue("r_slt", R, F7B, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, L1);
        issue("r_sltu", R, F7B, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, L1);
        issue("r_xor", R, F7B, 3'b100, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, L1);
        issue("r_srl", R, F7B, 3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, L1);
        issue("r_sra", R, F7A, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, L1);
        issue("r_or", R, F7B, 3'b110, 32'h0F, 32'hF0, 32'hFF, 1'b0, L1);

        issue("i_srai", I, F7A, 3'b101, 32'hFFFF_FFF0, 32'd2, 32'hFFFF_FFFC, 1'b0, L1);
        issue("i_slli_bad", I, F7A, 3'b001, 32'd1, 32'd1, 32'd0, 1'b1, L1);
        issue("i_addi", I, F7A, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0, L1);
        issue("i_sri_bad", I, F7M, 3'b101, 32'd8, 32'd1, 32'd0, 1'b1, L1);

        issue("mul", R, F7M, 3'b000, 32'd7, 32'd6, 32'd42, 1'b0, LM);
        issue("mul_neg", R, F7M, 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, LM);
        issue("mulh_m1m1", R, F7M, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, LM);
        issue("mulhsu", R, F7M, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, LM);
        issue("mulhu", R, F7M, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, LM);
        issue("div_neg", R, F7M, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, LM);
        issue("rem_neg", R, F7M, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, LM);
        issue("rem_ovf", R, F7M, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, LM);
        issue("div_by0", R, F7M, 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0, LM);
        issue("rem_by0", R, F7M, 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, LM);
        issue("divu", R, F7M, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, LM);
        issue("remu", R, F7M, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, LM);
        issue("r_bad_f7", R, 7'b0000010, 3'b000, 32'd1, 32'd2, 32'd0, 1'b1, L1);

        // Hold an and-result for 5 cycles, then stream 10 adds with the consumer always ready.
        wait_drain();
        out_ready = 1'b0;
        issue("r_and_stall", R, F7B, 3'b111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, L1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue($sformatf("stream_add%0d", i), 2'b00, F7B, 3'b000, 32'(i * 3 + 1), 32'(i + 100),
                  32'(4 * i + 101), 1'b0, L1);
            if (i == 0) first_acc = last_acc;
        end
        check("stream accept span", 64'(last_acc - first_acc), 64'd9);
        wait_drain();

        // Abort a divide with reset partway through its iterations.
        issue("div_aborted", R, F7M, 3'b100, 32'd100, 32'd7, 32'd14, 1'b0, LM);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort out_valid", {63'd0, out_valid}, 64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort zero", {63'd0, zero}, 64'd1);
        check("abort in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_abort out_valid", {63'd0, out_valid}, 64'd0);

        issue("r_sub_bad_f3", R, F7A, 3'b111, 32'd5, 32'd7, 32'd0, 1'b1, L1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
